// File: rtl/operand_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : operand_stage_if
//  Description : Signal bundle for the operand-fetch stage. It carries the
//                decode-side handshake and payload, the register-file read
//                ports, the MEM and WB stage snoop buses used for hazard
//                detection and forwarding, the EX-side handshake and payload,
//                and the stall counter.
//  Modports    : slave  - the operand stage itself
//                master - the surrounding pipeline / environment
//  Revision    : 1.0 - initial release
// ============================================================================
interface operand_stage_if;
    // Decode -> operand stage
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic        in_is_load;
    logic [31:0] in_imm;
    logic [15:0] in_ctrl;

    // Register-file read ports (combinational, x0 reads as zero)
    logic [4:0]  rf_rs1;
    logic [4:0]  rf_rs2;
    logic [31:0] rf_data1;
    logic [31:0] rf_data2;

    // MEM stage snoop
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic        mem_rd_wen;
    logic        mem_is_load;
    logic [31:0] mem_result;

    // WB stage snoop (also drives the register-file write port)
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic [31:0] wb_data;

    // Pipeline control
    logic        flush;
    logic        ex_ready;

    // Operand stage -> EX
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_rd_wen;
    logic        ex_is_load;
    logic [15:0] ex_ctrl;
    logic [31:0] stall_cnt;

    modport slave (
        input  in_valid, in_pc, in_rs1, in_rs2, in_rd, in_rd_wen, in_is_load,
               in_imm, in_ctrl,
        output in_ready,
        output rf_rs1, rf_rs2,
        input  rf_data1, rf_data2,
        input  mem_valid, mem_rd, mem_rd_wen, mem_is_load, mem_result,
        input  wb_valid, wb_rd, wb_wen, wb_data,
        input  flush, ex_ready,
        output ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd, ex_rd_wen,
               ex_is_load, ex_ctrl, stall_cnt
    );

    modport master (
        output in_valid, in_pc, in_rs1, in_rs2, in_rd, in_rd_wen, in_is_load,
               in_imm, in_ctrl,
        input  in_ready,
        input  rf_rs1, rf_rs2,
        output rf_data1, rf_data2,
        output mem_valid, mem_rd, mem_rd_wen, mem_is_load, mem_result,
        output wb_valid, wb_rd, wb_wen, wb_data,
        output flush, ex_ready,
        input  ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd, ex_rd_wen,
               ex_is_load, ex_ctrl, stall_cnt
    );
endinterface : operand_stage_if
`default_nettype wire

// File: rtl/operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : operand_stage
//  Description : Operand-fetch pipeline stage. Reads the register file for
//                the incoming instruction, detects read-after-write hazards
//                against the EX, MEM and WB stages, optionally forwards
//                results from MEM/WB, and registers the instruction plus its
//                resolved operands into the EX pipeline register.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - operand_stage_if.slave (decode handshake, register
//                         file read ports, MEM/WB snoop, flush, EX handshake
//                         and payload, stall counter)
//  Config      : FORWARD_EN - when defined, MEM (non-load) and WB results are
//                bypassed into the operands and only EX matches and MEM load
//                matches stall. When undefined, operands come only from the
//                register file and any EX/MEM/WB match stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_stage (
    input  wire logic      clk,
    input  wire logic      rst_n,
    operand_stage_if.slave bus
);

    localparam logic [4:0] c_X0 = 5'd0;

    // ------------------------------------------------------------------------
    // EX pipeline register
    // ------------------------------------------------------------------------
    logic        r_ex_valid;
    logic [31:0] r_ex_pc;
    logic [31:0] r_ex_op1;
    logic [31:0] r_ex_op2;
    logic [31:0] r_ex_imm;
    logic [4:0]  r_ex_rd;
    logic        r_ex_rd_wen;
    logic        r_ex_is_load;
    logic [15:0] r_ex_ctrl;
    logic [31:0] r_stall_cnt;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic        w_ex_m1;
    logic        w_ex_m2;
    logic        w_mem_m1;
    logic        w_mem_m2;
    logic        w_wb_m1;
    logic        w_wb_m2;
    logic        w_hazard;
    logic        w_in_ready;
    logic        w_advance;
    logic        w_accept;
    logic [31:0] w_op1;
    logic [31:0] w_op2;

    // A producer stage matches a source register only when it holds a valid
    // instruction that writes that register; x0 is hard-wired and never
    // creates a dependency.
    function automatic logic f_match(
        input logic       stage_valid,
        input logic       stage_wen,
        input logic [4:0] stage_rd,
        input logic [4:0] src
    );
        return stage_valid & stage_wen & (stage_rd == src) & (src != c_X0);
    endfunction

    // Register-file read addresses come straight from decode.
    assign bus.rf_rs1 = bus.in_rs1;
    assign bus.rf_rs2 = bus.in_rs2;

    assign w_ex_m1  = f_match(r_ex_valid, r_ex_rd_wen, r_ex_rd, bus.in_rs1);
    assign w_ex_m2  = f_match(r_ex_valid, r_ex_rd_wen, r_ex_rd, bus.in_rs2);
    assign w_mem_m1 = f_match(bus.mem_valid, bus.mem_rd_wen, bus.mem_rd, bus.in_rs1);
    assign w_mem_m2 = f_match(bus.mem_valid, bus.mem_rd_wen, bus.mem_rd, bus.in_rs2);
    assign w_wb_m1  = f_match(bus.wb_valid, bus.wb_wen, bus.wb_rd, bus.in_rs1);
    assign w_wb_m2  = f_match(bus.wb_valid, bus.wb_wen, bus.wb_rd, bus.in_rs2);

`ifdef FORWARD_EN
    // The EX result does not exist yet, so an EX match always stalls. A load
    // in MEM has no data until WB, so it stalls too; everything else is
    // bypassed with MEM taking priority as the younger producer.
    assign w_hazard = bus.in_valid &
                      (w_ex_m1 | w_ex_m2 |
                       (bus.mem_is_load & (w_mem_m1 | w_mem_m2)));

    assign w_op1 = (w_mem_m1 & ~bus.mem_is_load) ? bus.mem_result :
                   w_wb_m1                       ? bus.wb_data    :
                                                   bus.rf_data1;
    assign w_op2 = (w_mem_m2 & ~bus.mem_is_load) ? bus.mem_result :
                   w_wb_m2                       ? bus.wb_data    :
                                                   bus.rf_data2;
`else
    // Without bypassing the instruction waits until the producer has written
    // the register file; the write lands on the edge that retires WB, so the
    // read on the following cycle sees it.
    assign w_hazard = bus.in_valid &
                      (w_ex_m1 | w_ex_m2 | w_mem_m1 | w_mem_m2 |
                       w_wb_m1 | w_wb_m2);

    assign w_op1 = bus.rf_data1;
    assign w_op2 = bus.rf_data2;

    // Snoop data is only needed by the forwarding network.
    logic w_unused_fwd;
    assign w_unused_fwd = &{1'b0, bus.mem_result, bus.mem_is_load, bus.wb_data};
`endif

    // EX can take a new entry when it is empty or draining this cycle; a
    // flush cycle never accepts because its edge discards EX contents.
    assign w_advance  = ~bus.flush & (~r_ex_valid | bus.ex_ready);
    assign w_in_ready = ~w_hazard & w_advance;
    assign w_accept   = bus.in_valid & w_in_ready;

    assign bus.in_ready = w_in_ready;

    // ------------------------------------------------------------------------
    // EX register update
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid   <= 1'b0;
            r_ex_pc      <= 32'd0;
            r_ex_op1     <= 32'd0;
            r_ex_op2     <= 32'd0;
            r_ex_imm     <= 32'd0;
            r_ex_rd      <= 5'd0;
            r_ex_rd_wen  <= 1'b0;
            r_ex_is_load <= 1'b0;
            r_ex_ctrl    <= 16'd0;
        end else if (bus.flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_advance) begin
            // A hazard while EX moves on leaves a bubble behind; the stale
            // payload is kept since ex_valid marks it as meaningless.
            r_ex_valid <= bus.in_valid & ~w_hazard;
            if (w_accept) begin
                r_ex_pc      <= bus.in_pc;
                r_ex_op1     <= w_op1;
                r_ex_op2     <= w_op2;
                r_ex_imm     <= bus.in_imm;
                r_ex_rd      <= bus.in_rd;
                r_ex_rd_wen  <= bus.in_rd_wen;
                r_ex_is_load <= bus.in_is_load;
                r_ex_ctrl    <= bus.in_ctrl;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stall counter: cycles where decode offers an instruction that cannot be
    // taken, for any reason other than a flush. Wraps naturally at 2^32.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
        end else if (bus.in_valid & ~w_in_ready & ~bus.flush) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.ex_valid   = r_ex_valid;
    assign bus.ex_pc      = r_ex_pc;
    assign bus.ex_op1     = r_ex_op1;
    assign bus.ex_op2     = r_ex_op2;
    assign bus.ex_imm     = r_ex_imm;
    assign bus.ex_rd      = r_ex_rd;
    assign bus.ex_rd_wen  = r_ex_rd_wen;
    assign bus.ex_is_load = r_ex_is_load;
    assign bus.ex_ctrl    = r_ex_ctrl;
    assign bus.stall_cnt  = r_stall_cnt;

endmodule : operand_stage
`default_nettype wire
